// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [4:0] REG_X0    = 5'd0;
    localparam int         CNT_W_DEF = 32;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the load in EX and the operands of ID.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic rs1_match_s;
    logic rs2_match_s;

    assign rs1_match_s = (ex_rd == id_rs1);
    assign rs2_match_s = id_uses_rs2 && (ex_rd == id_rs2);
    // x0 is hard-wired zero, so a load targeting it never produces a dependency
    assign hazard = ex_mem_read && (ex_rd != REG_X0) && (rs1_match_s || rs2_match_s);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: post-reset flush, load-use bubbles, redirect squash, debug halt.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int INIT_CYCLES      = 2,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_Rs1,
    input  logic [4:0]       ID_Rs2,
    input  logic             ID_UsesRs2,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rdReg,
    input  logic             EX_Taken,
    input  logic             EX_Jump,
    input  logic             halt_req,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFflush,
    output logic             EXflush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [3:0] INIT_CNT  = 4'(INIT_CYCLES - 1);
    localparam logic [3:0] STALL_CNT = (LOAD_USE_BUBBLES > 1) ? 4'(LOAD_USE_BUBBLES - 2) : 4'd0;

    state_e     state_r;
    state_e     state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       halted_r;
    logic       hazard_s;
    logic       redirect_s;
    logic       pc_write_s;
    logic       ifid_write_s;
    logic       if_flush_s;
    logic       ex_flush_s;

    hazard_detect u_detect (
        .id_rs1      (ID_Rs1),
        .id_rs2      (ID_Rs2),
        .id_uses_rs2 (ID_UsesRs2),
        .ex_mem_read (EX_MemRead),
        .ex_rd       (EX_rdReg),
        .hazard      (hazard_s)
    );

    assign redirect_s = (state_r == ST_RUN) && (EX_Taken || EX_Jump);

    // Mealy control outputs from current state and inputs
    always_comb begin
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        if_flush_s   = 1'b1;
        ex_flush_s   = 1'b1;
        case (state_r)
            ST_INIT: begin
                pc_write_s   = 1'b0;
                ifid_write_s = 1'b0;
                if_flush_s   = 1'b1;
                ex_flush_s   = 1'b1;
            end
            ST_RUN: begin
                if (redirect_s) begin
                    pc_write_s   = 1'b1;
                    ifid_write_s = 1'b1;
                    if_flush_s   = 1'b1;
                    ex_flush_s   = 1'b1;
                end else if (hazard_s) begin
                    pc_write_s   = 1'b0;
                    ifid_write_s = 1'b0;
                    if_flush_s   = 1'b0;
                    ex_flush_s   = 1'b1;
                end else begin
                    pc_write_s   = 1'b1;
                    ifid_write_s = 1'b1;
                    if_flush_s   = 1'b0;
                    ex_flush_s   = 1'b0;
                end
            end
            ST_STALL, ST_HALT: begin
                pc_write_s   = 1'b0;
                ifid_write_s = 1'b0;
                if_flush_s   = 1'b0;
                ex_flush_s   = 1'b1;
            end
            default: begin
                pc_write_s   = 1'b0;
                ifid_write_s = 1'b0;
                if_flush_s   = 1'b1;
                ex_flush_s   = 1'b1;
            end
        endcase
    end

    // Next-state and sequencing counter selection
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_RUN: begin
                if (redirect_s) begin
                    state_nxt_s = ST_RUN;
                end else if (hazard_s) begin
                    // the hazard cycle itself is the first bubble
                    if (LOAD_USE_BUBBLES > 1) begin
                        state_nxt_s = ST_STALL;
                        cnt_nxt_s   = STALL_CNT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (halt_req) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STALL: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_HALT: begin
                if (halt_req) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
                cnt_nxt_s   = INIT_CNT;
            end
        endcase
    end

    // State, sequencing counter and halted flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_INIT;
            cnt_r    <= INIT_CNT;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            halted_r <= (state_nxt_s == ST_HALT);
        end
    end

    assign PCWrite   = pc_write_s;
    assign IFIDWrite = ifid_write_s;
    assign IFflush   = if_flush_s;
    assign EXflush   = ex_flush_s;
    assign halted    = halted_r;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             bubble_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    assign bubble_s = ex_flush_s && !pc_write_s && (state_r != ST_INIT);

    // Saturating bubble and redirect event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (bubble_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with single-bubble loads, one with three.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ID_Rs1;
    logic [4:0]  ID_Rs2;
    logic        ID_UsesRs2;
    logic        EX_MemRead;
    logic [4:0]  EX_rdReg;
    logic        EX_Taken;
    logic        EX_Jump;
    logic        halt_req;

    logic        pc1, ifid1, iff1, exf1, halted1;
    logic [31:0] sc1, fc1;
    logic        pc3, ifid3, iff3, exf3, halted3;
    logic [31:0] sc3, fc3;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] NORM  = 4'b1100;
    localparam logic [3:0] BUB   = 4'b0001;
    localparam logic [3:0] INITV = 4'b0011;
    localparam logic [3:0] REDIR = 4'b1111;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.INIT_CYCLES(2), .LOAD_USE_BUBBLES(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_UsesRs2(ID_UsesRs2),
        .EX_MemRead(EX_MemRead), .EX_rdReg(EX_rdReg), .EX_Taken(EX_Taken), .EX_Jump(EX_Jump),
        .halt_req(halt_req), .PCWrite(pc1), .IFIDWrite(ifid1), .IFflush(iff1), .EXflush(exf1),
        .halted(halted1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_ctrl #(.INIT_CYCLES(2), .LOAD_USE_BUBBLES(3), .CNT_W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_UsesRs2(ID_UsesRs2),
        .EX_MemRead(EX_MemRead), .EX_rdReg(EX_rdReg), .EX_Taken(EX_Taken), .EX_Jump(EX_Jump),
        .halt_req(halt_req), .PCWrite(pc3), .IFIDWrite(ifid3), .IFflush(iff3), .EXflush(exf3),
        .halted(halted3), .stall_cnt(sc3), .flush_cnt(fc3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pexp(input logic [31:0] n);
        return PERF ? n : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ID_Rs1     = 5'd0;
        ID_Rs2     = 5'd0;
        ID_UsesRs2 = 1'b0;
        EX_MemRead = 1'b0;
        EX_rdReg   = 5'd0;
        EX_Taken   = 1'b0;
        EX_Jump    = 1'b0;
        halt_req   = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1);
        EX_MemRead = 1'b1;
        EX_rdReg   = rd;
        ID_Rs1     = rs1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        chk("rst_outs",   {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, INITV});
        chk("rst_halted", {31'd0, halted1}, 32'd0);
        chk("rst_scnt",   sc1, 32'd0);
        chk("rst_fcnt",   fc1, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("init_edge0", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, INITV});
        tick();
        chk("init_edge1", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, INITV});
        tick();
        chk("run_after_init", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, NORM});

        // load x5 in EX, add rs1=x5 in ID
        load_use(5'd5, 5'd5);
        #1;
        chk("lu_bubble", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, BUB});
        tick();
        idle();
        #1;
        chk("lu_resume", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, NORM});
        chk("lu_scnt", sc1, pexp(32'd1));

        load_use(5'd0, 5'd0);
        #1;
        chk("rd0_nostall", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, NORM});
        tick();
        idle();

        load_use(5'd5, 5'd3);
        ID_Rs2 = 5'd5;
        #1;
        chk("rs2_unused", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, NORM});
        ID_UsesRs2 = 1'b1;
        #1;
        chk("rs2_used", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, BUB});
        tick();
        idle();
        #1;
        chk("rs2_resume", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, NORM});
        chk("rs2_scnt", sc1, pexp(32'd2));

        load_use(5'd5, 5'd5);
        EX_Taken = 1'b1;
        #1;
        chk("taken_hz", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, REDIR});
        tick();
        idle();
        #1;
        chk("taken_after", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, NORM});
        chk("taken_fcnt", fc1, pexp(32'd1));
        chk("taken_scnt", sc1, pexp(32'd2));

        EX_Jump = 1'b1;
        #1;
        chk("jump", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, REDIR});
        tick();
        idle();
        #1;
        chk("jump_fcnt", fc1, pexp(32'd2));

        halt_req = 1'b1;
        #1;
        chk("halt_req_adv", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, NORM});
        chk("halt_req_hflag", {31'd0, halted1}, 32'd0);
        tick();
        chk("halt_outs", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, BUB});
        chk("halt_hflag", {31'd0, halted1}, 32'd1);
        tick();
        halt_req = 1'b0;
        #1;
        chk("halt_fall", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, BUB});
        chk("halt_fall_hflag", {31'd0, halted1}, 32'd1);
        tick();
        chk("halt_exit", {28'd0, pc1, ifid1, iff1, exf1}, {28'd0, NORM});
        chk("halt_exit_hflag", {31'd0, halted1}, 32'd0);
        chk("halt_scnt", sc1, pexp(32'd4));

        // fresh start for the three-bubble instance
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("d3_run", {28'd0, pc3, ifid3, iff3, exf3}, {28'd0, NORM});
        chk("d3_rst_scnt", sc3, 32'd0);

        load_use(5'd5, 5'd5);
        halt_req = 1'b1;
        #1;
        chk("d3_bub1", {28'd0, pc3, ifid3, iff3, exf3}, {28'd0, BUB});
        tick();
        idle();
        halt_req = 1'b1;
        #1;
        chk("d3_bub2", {28'd0, pc3, ifid3, iff3, exf3}, {28'd0, BUB});
        chk("d3_bub2_hflag", {31'd0, halted3}, 32'd0);
        tick();
        chk("d3_bub3", {28'd0, pc3, ifid3, iff3, exf3}, {28'd0, BUB});
        tick();
        chk("d3_adv", {28'd0, pc3, ifid3, iff3, exf3}, {28'd0, NORM});
        chk("d3_adv_hflag", {31'd0, halted3}, 32'd0);
        chk("d3_scnt3", sc3, pexp(32'd3));
        tick();
        chk("d3_halt", {28'd0, pc3, ifid3, iff3, exf3}, {28'd0, BUB});
        chk("d3_halt_hflag", {31'd0, halted3}, 32'd1);
        halt_req = 1'b0;
        #1;
        chk("d3_halt_fall", {28'd0, pc3, ifid3, iff3, exf3}, {28'd0, BUB});
        tick();
        chk("d3_resume", {28'd0, pc3, ifid3, iff3, exf3}, {28'd0, NORM});
        chk("d3_resume_hflag", {31'd0, halted3}, 32'd0);
        chk("d3_scnt4", sc3, pexp(32'd4));

        // enter STALL, show a redirect is ignored there, then reset asynchronously
        load_use(5'd7, 5'd7);
        #1;
        chk("d3_hz2", {28'd0, pc3, ifid3, iff3, exf3}, {28'd0, BUB});
        tick();
        idle();
        EX_Taken = 1'b1;
        #1;
        chk("d3_stall_taken", {28'd0, pc3, ifid3, iff3, exf3}, {28'd0, BUB});
        tick();
        chk("d3_stall_fcnt", fc3, pexp(32'd0));
        chk("d3_stall_scnt", sc3, pexp(32'd6));
        rst_n = 1'b0;
        #1;
        chk("d3_async_rst", {28'd0, pc3, ifid3, iff3, exf3}, {28'd0, INITV});
        chk("d3_async_hflag", {31'd0, halted3}, 32'd0);
        chk("d3_async_scnt", sc3, 32'd0);
        chk("d3_async_fcnt", fc3, 32'd0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
